// File: rtl/prga_chunked_addsub.sv
// prga_chunked_addsub: multi-cycle add/sub, one CHUNK_WIDTH carry chain per cycle.
// Define PRGA_ADDSUB_CMP_EN to add the o_lt output and the 10/11 compare ops.
module prga_chunked_addsub #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_cout
`ifdef PRGA_ADDSUB_CMP_EN
    ,
    output logic                  o_lt
`endif
);
    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IW = $clog2(NCHUNK);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]             op_q, op_d, acc_op;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   carry_q, carry_d, last, sub;
    logic [CHUNK_WIDTH:0]   sum;

`ifdef PRGA_ADDSUB_CMP_EN
    logic lt_q, lt_d, r_msb, ovf;
    assign acc_op = i_op;
`else
    logic unused_op;
    assign unused_op = i_op[1];
    assign acc_op    = {1'b0, i_op[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_valid ? BUSY : IDLE;
            BUSY:    state_d = last ? DONE : BUSY;
            DONE:    state_d = o_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ready = state_q == IDLE;
        o_valid = state_q == DONE;
    end

    assign last     = idx_q == IW'(NCHUNK - 1);
    assign sub      = |op_q;
    assign o_result = res_q;
    assign o_cout   = carry_q;

    // Operands shift right one chunk per cycle, so chunk k always sits in the low bits;
    // the result fills from the top and is complete after NCHUNK shifts.
    always_comb begin
        sum     = {1'b0, a_q[CHUNK_WIDTH-1:0]}
                + {1'b0, b_q[CHUNK_WIDTH-1:0] ^ {CHUNK_WIDTH{sub}}}
                + {{CHUNK_WIDTH{1'b0}}, carry_q};
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        res_d   = res_q;
        if (state_q == IDLE && i_valid) begin
            a_d     = i_a;
            b_d     = i_b;
            op_d    = acc_op;
            idx_d   = '0;
            carry_d = |acc_op;
        end else if (state_q == BUSY) begin
            a_d     = a_q >> CHUNK_WIDTH;
            b_d     = b_q >> CHUNK_WIDTH;
            res_d   = {sum[CHUNK_WIDTH-1:0], res_q[DATA_WIDTH-1:CHUNK_WIDTH]};
            carry_d = sum[CHUNK_WIDTH];
            idx_d   = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
        end
    end

`ifdef PRGA_ADDSUB_CMP_EN
    // On the last chunk the low bits hold the original top chunk, so its msb is the sign.
    always_comb begin
        r_msb = sum[CHUNK_WIDTH-1];
        ovf   = (a_q[CHUNK_WIDTH-1] ^ b_q[CHUNK_WIDTH-1]) & (a_q[CHUNK_WIDTH-1] ^ r_msb);
        lt_d  = lt_q;
        if (state_q == BUSY && last)
            lt_d = (op_q == 2'b10) ? ~sum[CHUNK_WIDTH] : (op_q == 2'b11) ? r_msb ^ ovf : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lt_q <= 1'b0;
        else        lt_q <= lt_d;
    end

    assign o_lt = lt_q;
`endif
endmodule

// File: doc/prga_chunked_addsub.md
PRGA_CHUNKED_ADDSUB -- requirements
Module: prga_chunked_addsub

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 16: bits added per cycle on one carry chain; DATA_WIDTH SHALL be an integer multiple of CHUNK_WIDTH, with NCHUNK = DATA_WIDTH/CHUNK_WIDTH >= 2.
REQ-003 SHALL have the ports below, clock and reset first; one clock, reset asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 i_ready  output  1  block can accept a request.
REQ-008 i_op  input  2  00 add, 01 sub, 10 unsigned less-than, 11 signed less-than.
REQ-009 i_a, i_b  input  DATA_WIDTH  operands.
REQ-010 o_valid  output  1  result valid.
REQ-011 o_ready  input  1  consumer accepts result.
REQ-012 o_result  output  DATA_WIDTH  sum or difference.
REQ-013 o_cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-014 o_lt  output  1  comparison flag; present only with the Configuration macro.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-016 IDLE: i_ready=1; i_valid=1 captures i_a, i_b, i_op, clears chunk index, loads carry register with 1 for op!=00 and 0 for op=00, goes to BUSY.
REQ-017 BUSY: each cycle adds chunk k of A and chunk k of B (B inverted for op!=00) plus the carry register, writes chunk k of the result register, stores chunk carry-out; after chunk NCHUNK-1, goes to DONE.
REQ-018 Latency SHALL be exactly NCHUNK cycles from the accepting edge to the edge raising o_valid (4 at defaults).
REQ-019 DONE: o_valid=1; o_result, o_cout, o_lt SHALL stay stable until o_ready=1, then return to IDLE on that edge.
REQ-020 i_ready SHALL be 0 in BUSY and DONE; no request is accepted in the cycle a result is consumed (one idle cycle between results).
REQ-021 Arithmetic modulo 2^DATA_WIDTH; sub computes A + ~B + 1; o_cout = final carry.
REQ-022 Chunk-to-chunk carry SHALL pass only through the carry register; no combinational path spans more than CHUNK_WIDTH bits.
REQ-023 i_a, i_b, i_op changes outside the accepting cycle SHALL NOT affect the result.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, i_ready=1 once released, o_valid=0, o_result=0, o_cout=0, o_lt=0, carry and index registers 0.
REQ-025 Reset during BUSY or DONE SHALL discard the operation; no result is ever delivered for it.

Configuration
REQ-026 Macro PRGA_ADDSUB_CMP_EN: when defined, o_lt exists; ops 10/11 perform sub and set o_lt = ~cout (10) or R[msb] ^ V with V = (A[msb]^B[msb]) & (A[msb]^R[msb]) (11); o_lt=0 for ops 00/01.
REQ-027 When undefined, o_lt port SHALL be absent and i_op[1] ignored (10 behaves as 00, 11 as 01).

Verification (DATA_WIDTH=64, CHUNK_WIDTH=16)
REQ-028 add 0xFFFF_FFFF_FFFF_FFFF + 0x1, o_ready=1 -> o_valid 4 cycles after accept, o_result=0, o_cout=1, single-cycle o_valid.
REQ-029 sub 0x0 - 0x1 -> o_result=0xFFFF_FFFF_FFFF_FFFF, o_cout=0; sub 0x10 - 0x10 -> 0, o_cout=1.
REQ-030 (macro on) op 11, A=0x8000_0000_0000_0000, B=0x1 -> o_lt=1; same operands op 10 -> o_lt=0.
REQ-031 hold o_ready=0 for 3 cycles in DONE, toggle i_a/i_valid -> outputs unchanged, i_ready=0; o_ready=1 -> IDLE next edge, one idle cycle before next accept.
REQ-032 assert rst_n=0 in 2nd BUSY cycle, release, issue add 2+3 -> o_result=5 only; no stale result observed.
